uart_cmd_parser: RTL

Byte-to-command framer sitting directly downstream of the UART receiver. Consumes received bytes (`rx_data`/`rx_ready`), hunts for a sync byte, assembles fixed-length command frames, validates them and presents each decoded command on a valid/ready interface to the sensor control logic. Malformed, stalled or dropped frames are counted and flagged.

---
 rtl/uart_cmd_pkg.sv | 22 ++
 rtl/uart_cmd_timeout.sv | 37 +++
 rtl/uart_cmd_parser.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command framer: FSM encoding,
// error bit positions and frame lengths for both checksum configurations.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ARG_HI = 3'd2,
    ST_ARG_LO = 3'd3,
    ST_CHK    = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam int ERR_CHK = 0;
  localparam int ERR_TMO = 1;
  localparam int ERR_OVF = 2;

  localparam int FRAME_LEN_CHK   = 5;
  localparam int FRAME_LEN_NOCHK = 4;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte stall detector: counts baud8 ticks while a frame is open and
// pulses expire_o on the tick that reaches TIMEOUT_TICKS.
module uart_cmd_timeout #(
  parameter logic [7:0] TIMEOUT_TICKS = 8'd240
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic tick_i,
  output logic expire_o
);

  logic [7:0] count_q, count_d;

  // A byte arriving on the expiring tick wins: the frame is still alive.
  always_comb begin
    count_d  = count_q;
    expire_o = 1'b0;
    if (clr_i || !en_i) begin
      count_d = '0;
    end else if (tick_i) begin
      if (count_q == TIMEOUT_TICKS - 8'd1) begin
        expire_o = 1'b1;
        count_d  = '0;
      end else begin
        count_d = count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Byte-to-command framer behind the UART receiver.
// Build option: define UART_CMD_CHECKSUM_EN for the 5-byte frame with XOR check.
//
// state     | meaning
// ST_HUNT   | waiting for SYNC_BYTE, other bytes discarded
// ST_CMD    | expecting command byte
// ST_ARG_HI | expecting argument high byte
// ST_ARG_LO | expecting argument low byte
// ST_CHK    | expecting checksum byte (checksum build only)
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  parameter logic [7:0] TIMEOUT_TICKS = 8'd240
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        baud8_tick,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_code,
  output logic [15:0] cmd_arg,
  output logic [2:0]  err_flags,
  output logic [7:0]  err_count,
  input  logic        err_clr
);

  state_e      state_q;
  logic        rx_ready_q;
  logic [7:0]  code_q, hi_q;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]  lo_q, xor_q;
`endif
  logic        cmd_valid_q;
  logic [7:0]  cmd_code_q;
  logic [15:0] cmd_arg_q;
  logic [2:0]  err_flags_q;
  logic [7:0]  err_count_q;

  logic        accept, frame_done, chk_bad, commit_ok, ovf, load, tmo_expire;
  logic [15:0] new_arg;
  logic [2:0]  err_evt;

  always_comb begin
    accept = rx_ready & ~rx_ready_q;
`ifdef UART_CMD_CHECKSUM_EN
    frame_done = accept && (state_q == ST_CHK);
    chk_bad    = frame_done && (xor_q != rx_data);
    new_arg    = {hi_q, lo_q};
`else
    frame_done = accept && (state_q == ST_ARG_LO);
    chk_bad    = 1'b0;
    new_arg    = {hi_q, rx_data};
`endif
    commit_ok = frame_done & ~chk_bad;
    // A transfer in the commit cycle frees the slot, so only a stalled consumer overflows.
    ovf       = commit_ok & cmd_valid_q & ~cmd_ready;
    load      = commit_ok & ~ovf;
    err_evt          = '0;
    err_evt[ERR_CHK] = chk_bad;
    err_evt[ERR_TMO] = tmo_expire;
    err_evt[ERR_OVF] = ovf;
  end

  uart_cmd_timeout #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (accept),
    .en_i     (state_q != ST_HUNT),
    .tick_i   (baud8_tick),
    .expire_o (tmo_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_HUNT;
      rx_ready_q  <= 1'b0;
      code_q      <= '0;
      hi_q        <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      lo_q        <= '0;
      xor_q       <= '0;
`endif
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      cmd_arg_q   <= '0;
      err_flags_q <= '0;
      err_count_q <= '0;
    end else begin
      rx_ready_q <= rx_ready;

      if (tmo_expire) begin
        state_q <= ST_HUNT;
      end else if (accept) begin
        unique case (state_q)
          ST_HUNT:   if (rx_data == SYNC_BYTE) state_q <= ST_CMD;
          ST_CMD: begin
            code_q  <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
            xor_q   <= rx_data;
`endif
            state_q <= ST_ARG_HI;
          end
          ST_ARG_HI: begin
            hi_q    <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
            xor_q   <= xor_q ^ rx_data;
`endif
            state_q <= ST_ARG_LO;
          end
          ST_ARG_LO: begin
`ifdef UART_CMD_CHECKSUM_EN
            lo_q    <= rx_data;
            xor_q   <= xor_q ^ rx_data;
            state_q <= ST_CHK;
`else
            state_q <= ST_HUNT;
`endif
          end
          ST_CHK:    state_q <= ST_HUNT;
          default:   state_q <= ST_HUNT;
        endcase
      end

      if (load) begin
        cmd_valid_q <= 1'b1;
        cmd_code_q  <= code_q;
        cmd_arg_q   <= new_arg;
      end else if (cmd_valid_q && cmd_ready) begin
        cmd_valid_q <= 1'b0;
      end

      if (err_clr) begin
        err_flags_q <= '0;
        err_count_q <= '0;
      end else if (|err_evt) begin
        err_flags_q <= err_flags_q | err_evt;
        if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_arg   = cmd_arg_q;
  assign err_flags = err_flags_q;
  assign err_count = err_count_q;

endmodule
